// File: rtl/mul4_vector_scorer.sv
// Stimulus-and-scoring stage wrapped around one combinational mul4_vector
// candidate. The stage drives operand words, captures the candidate outputs
// next to the golden bit-sliced 2x2 products, and counts the matching bits.
// Each of the 16 bit positions is an independent 2-bit x 2-bit multiply.
module mul4_vector_scorer #(
    parameter int          NUM_VECTORS = 4,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SCORE_W     = $clog2(64*NUM_VECTORS+1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic [15:0]        o_a1,
    output logic [15:0]        o_a0,
    output logic [15:0]        o_b1,
    output logic [15:0]        o_b0,
    input  logic [15:0]        i_y3,
    input  logic [15:0]        i_y2,
    input  logic [15:0]        i_y1,
    input  logic [15:0]        i_y0,
    output logic               o_busy,
    output logic               o_done,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_perfect
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]        SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int                 IDX_W     = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(64 * NUM_VECTORS);

    // Vector 0 enumerates all 16 operand combinations across the bit positions.
    localparam logic [15:0] VEC0_A1 = 16'hFF00;
    localparam logic [15:0] VEC0_A0 = 16'hF0F0;
    localparam logic [15:0] VEC0_B1 = 16'hCCCC;
    localparam logic [15:0] VEC0_B0 = 16'hAAAA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [15:0]        r_a1, r_a0, r_b1, r_b0;
    logic [15:0]        r_lfsr;
    logic [IDX_W-1:0]   r_idx;
    logic [63:0]        r_capY;
    logic [63:0]        r_capG;
    logic               r_capValid;
    logic [SCORE_W-1:0] r_accum;
    logic [SCORE_W-1:0] r_score;
    logic               r_perfect;
    logic               r_busy;
    logic               r_done;

    logic [15:0]        w_lfsr1, w_lfsr2, w_lfsr3, w_lfsr4;
    logic [15:0]        w_g0, w_g1, w_g2, w_g3, w_carry;
    logic [63:0]        w_gold;
    logic [6:0]         w_pop;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Number of set bits in a 64-bit word (0..64).
    function automatic logic [6:0] popCount64(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    // Four successive LFSR states feed one vector: a1, a0, b1, b0 in that order.
    always_comb begin
        w_lfsr1 = lfsrStep(r_lfsr);
        w_lfsr2 = lfsrStep(w_lfsr1);
        w_lfsr3 = lfsrStep(w_lfsr2);
        w_lfsr4 = lfsrStep(w_lfsr3);
    end

    // Golden bit-sliced 2x2 product of the operands currently on the outputs.
    always_comb begin
        w_carry = r_a1 & r_a0 & r_b1 & r_b0;
        w_g0    = r_a0 & r_b0;
        w_g1    = (r_a1 & r_b0) ^ (r_a0 & r_b1);
        w_g2    = (r_a1 & r_b1) ^ w_carry;
        w_g3    = w_carry;
        w_gold  = {w_g3, w_g2, w_g1, w_g0};
    end

    // Count of captured output bits that agree with the golden bits.
    always_comb begin
        w_pop = popCount64(~(r_capY ^ r_capG));
    end

    // Next-state logic for the evaluation sequencer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_nextState = S_DRIVE;
            S_DRIVE: if (r_idx == LAST_IDX) w_nextState = S_FLUSH;
            S_FLUSH: w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register; reset returns to IDLE regardless of any pending start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand generation, capture stage, accumulation and result registers.
    // Capture only happens in DRIVE, so y values outside DRIVE never reach the score.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a1       <= '0;
            r_a0       <= '0;
            r_b1       <= '0;
            r_b0       <= '0;
            r_lfsr     <= SEED_EFF;
            r_idx      <= '0;
            r_capY     <= '0;
            r_capG     <= '0;
            r_capValid <= 1'b0;
            r_accum    <= '0;
            r_score    <= '0;
            r_perfect  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_capValid <= 1'b0;
            r_done     <= 1'b0;
            if (r_capValid) begin
                r_accum <= r_accum + SCORE_W'(w_pop);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a1    <= VEC0_A1;
                        r_a0    <= VEC0_A0;
                        r_b1    <= VEC0_B1;
                        r_b0    <= VEC0_B0;
                        r_lfsr  <= SEED_EFF;
                        r_idx   <= '0;
                        r_accum <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    r_capY     <= {i_y3, i_y2, i_y1, i_y0};
                    r_capG     <= w_gold;
                    r_capValid <= 1'b1;
                    if (r_idx != LAST_IDX) begin
                        r_a1   <= r_lfsr;
                        r_a0   <= w_lfsr1;
                        r_b1   <= w_lfsr2;
                        r_b0   <= w_lfsr3;
                        r_lfsr <= w_lfsr4;
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                S_FLUSH: begin
                end
                S_DONE: begin
                    r_score   <= r_accum;
                    r_perfect <= (r_accum == MAX_SCORE);
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_a1      <= '0;
                    r_a0      <= '0;
                    r_b1      <= '0;
                    r_b0      <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_a1      = r_a1;
    assign o_a0      = r_a0;
    assign o_b1      = r_b1;
    assign o_b0      = r_b0;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_score   = r_score;
    assign o_perfect = r_perfect;

endmodule
